mem_responder: RTL and testbench

- Memory-side responder for the datapath's MAR/MDR memory port.
- Accepts one Read or Write request at a time and performs it on an internal 32-bit word RAM after a programmable number of wait states.
- Returns read data on Mdatain, which feeds the MDR input mux, and pulses mem_ready on completion.
- The control sequencer stalls on mem_busy / mem_ready.

---
 rtl/mini_src_pkg.sv | 17 +
 rtl/mem_array.sv | 33 +++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
package mini_src_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered, read-enabled output.
// The output register holds its value until the next enabled read or clr.
module mem_array
  import mini_src_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents are never cleared; only the read register resets.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR port: one request at a time, WAIT_CYCLES wait states.
// Optional macro MEM_RESPONDER_ADDR_CHECK_EN turns out-of-range addresses into addr_err.
module mem_responder
  import mini_src_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned MEM_DEPTH   = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              Read,
  input  logic              Write,
  input  logic [WORD_W-1:0] mdr_wdata,
  output logic [WORD_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMP_W = ADDR_W + 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_we_c, mem_re_c;
  logic              req_one_c, req_both_c, addr_bad_c;

  assign req_one_c  = Read ^ Write;
  assign req_both_c = Read & Write;

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign addr_bad_c = (CMP_W'(addr_q) >= CMP_W'(MEM_DEPTH));
`else
  assign addr_bad_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_one_c) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_one_c) begin
          op_d    = Write ? OP_WRITE : OP_READ;
          addr_d  = mar_addr;
          wdata_d = mdr_wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          busy_d  = 1'b1;
        end else if (req_both_c) begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (addr_bad_c) begin
          err_d = 1'b1;
        end else begin
          ready_d  = 1'b1;
          mem_we_c = (op_q == OP_WRITE) && !clr;
          mem_re_c = (op_q == OP_READ);
        end
      end
      RESP:    busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  mem_array #(
    .DEPTH(MEM_DEPTH),
    .AW   (IDX_W)
  ) u_mem (
    .clk  (clk),
    .clr  (clr),
    .we   (mem_we_c),
    .re   (mem_re_c),
    .addr (addr_q[IDX_W-1:0]),
    .wdata(wdata_q),
    .rdata(Mdatain)
  );

  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance A (WAIT_CYCLES=2, MEM_DEPTH=256), instance B (WAIT_CYCLES=0).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] dout_a, dout_b;
  logic        rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;
  logic        sel;
  logic [31:0] dout;
  logic        rdy, busy, err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(9), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .clr(clr), .mar_addr(addr), .Read(rd_a), .Write(wr_a),
    .mdr_wdata(wdata), .Mdatain(dout_a), .mem_ready(rdy_a),
    .mem_busy(busy_a), .addr_err(err_a)
  );

  mem_responder #(.ADDR_W(9), .MEM_DEPTH(512), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .clr(clr), .mar_addr(addr), .Read(rd_b), .Write(wr_b),
    .mdr_wdata(wdata), .Mdatain(dout_b), .mem_ready(rdy_b),
    .mem_busy(busy_b), .addr_err(err_b)
  );

  assign dout = sel ? dout_b : dout_a;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign busy = sel ? busy_b : busy_a;
  assign err  = sel ? err_b  : err_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_strobes();
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
  endtask

  // One full transaction; strobes drop right after acceptance and the
  // bus is scrambled so only latched values can reach the RAM.
  task automatic txn(input bit b, input bit rd, input bit wr, input logic [8:0] a,
                     input logic [31:0] d, input int exp_lat, input bit exp_err,
                     input string tag);
    int  n;
    bit  seen;
    sel   = b;
    addr  = a;
    wdata = d;
    if (b) begin rd_b = rd; wr_b = wr; end
    else   begin rd_a = rd; wr_a = wr; end
    tick();
    check({tag, " busy_acc"}, 32'(busy), 32'd1);
    drop_strobes();
    addr  = ~a;
    wdata = ~d;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = rdy | err;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " ready"}, 32'(rdy), 32'(!exp_err));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " busy_done"}, 32'(busy), 32'd1);
    tick();
    check({tag, " ready_drop"}, 32'(rdy), 32'd0);
    check({tag, " busy_drop"}, 32'(busy), 32'd0);
    check({tag, " err_drop"}, 32'(err), 32'd0);
  endtask

  initial begin
    sel   = 1'b0;
    addr  = '0;
    wdata = '0;
    drop_strobes();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    check("rst dout_a", dout_a, 32'd0);
    check("rst rdy_a", 32'(rdy_a), 32'd0);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst err_a", 32'(err_a), 32'd0);
    check("rst dout_b", dout_b, 32'd0);
    check("rst busy_b", 32'(busy_b), 32'd0);

    // Write/read round trip, two wait states
    txn(1'b0, 1'b0, 1'b1, 9'h012, 32'hDEADBEEF, 3, 1'b0, "wr012");
    check("wr012 dout_unchanged", dout_a, 32'd0);
    txn(1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3, 1'b0, "rd012");
    check("rd012 data", dout_a, 32'hDEADBEEF);
    tick();
    tick();
    check("rd012 hold", dout_a, 32'hDEADBEEF);

    // Zero wait states
    txn(1'b1, 1'b0, 1'b1, 9'h007, 32'h11223344, 1, 1'b0, "b_wr007");
    txn(1'b1, 1'b1, 1'b0, 9'h007, 32'h0, 1, 1'b0, "b_rd007");
    check("b_rd007 data", dout_b, 32'h11223344);

    // Simultaneous strobes
    txn(1'b0, 1'b0, 1'b1, 9'h030, 32'hCAFEF00D, 3, 1'b0, "wr030");
    sel   = 1'b0;
    addr  = 9'h030;
    wdata = 32'h0;
    rd_a  = 1'b1;
    wr_a  = 1'b1;
    tick();
    check("both err", 32'(err_a), 32'd1);
    check("both busy", 32'(busy_a), 32'd0);
    check("both rdy", 32'(rdy_a), 32'd0);
    drop_strobes();
    tick();
    check("both err_drop", 32'(err_a), 32'd0);
    check("both busy_after", 32'(busy_a), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 9'h030, 32'h0, 3, 1'b0, "rd030");
    check("rd030 data", dout_a, 32'hCAFEF00D);

    // Requests during ACCESS are ignored
    txn(1'b0, 1'b0, 1'b1, 9'h005, 32'h55AA55AA, 3, 1'b0, "wr005");
    sel  = 1'b0;
    addr = 9'h005;
    rd_a = 1'b1;
    tick();
    rd_a  = 1'b0;
    wr_a  = 1'b1;
    wdata = 32'h1;
    tick();
    wr_a = 1'b0;
    tick();
    check("ign rdy_early", 32'(rdy_a), 32'd0);
    tick();
    check("ign rdy", 32'(rdy_a), 32'd1);
    check("ign data", dout_a, 32'h55AA55AA);
    tick();
    tick();
    check("ign no_second", 32'(busy_a), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 9'h005, 32'h0, 3, 1'b0, "rd005");
    check("rd005 data", dout_a, 32'h55AA55AA);

    // Reset in the middle of a write
    txn(1'b0, 1'b0, 1'b1, 9'h020, 32'h13579BDF, 3, 1'b0, "wr020");
    sel   = 1'b0;
    addr  = 9'h020;
    wdata = 32'hA5A5A5A5;
    wr_a  = 1'b1;
    tick();
    wr_a = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr dout", dout_a, 32'd0);
    check("clr rdy", 32'(rdy_a), 32'd0);
    check("clr busy", 32'(busy_a), 32'd0);
    check("clr err", 32'(err_a), 32'd0);
    tick();
    tick();
    check("clr no_ready", 32'(rdy_a), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 3, 1'b0, "rd020");
    check("rd020 data", dout_a, 32'h13579BDF);

    // Out-of-range address on the 256-word instance
    txn(1'b0, 1'b0, 1'b1, 9'h0FF, 32'h0BADCAFE, 3, 1'b0, "wr0FF");
    txn(1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3, 1'b0, "rd012b");
    check("rd012b data", dout_a, 32'hDEADBEEF);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    txn(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0, 3, 1'b1, "rd1FF");
    check("rd1FF unchanged", dout_a, 32'hDEADBEEF);
`else
    txn(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0, 3, 1'b0, "rd1FF");
    check("rd1FF alias", dout_a, 32'h0BADCAFE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
